fifo_wr_arbiter: RTL

Round-robin arbiter that shares the single write port of a FIFO between NUM_REQ requesters. Each requester presents a valid/ready stream. The arbiter grants one requester at a time for a burst of up to MAX_BURST words and drives the FIFO write enable and write data. It sits in the FIFO's write clock domain, directly in front of the FIFO write port, and obeys the FIFO full flag.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/fifo_wr_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared state encoding, default data width and width helper for the
// FIFO write-port arbiter and its round-robin picker.
package fifo_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int DEF_SIZE_DATA = 8;

  // Ceiling log2 with a one-bit floor so a single-entry index still has a width.
  function automatic int clog2_f(input int value);
    int w;
    w = 1;
    while ((32'sd1 <<< w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one position past the
// last winner and the first asserted request found wins.
module rr_arbiter
  import fifo_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_f(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_id_o,
  output logic          any_req_o
);

  logic [IW-1:0] idx_s;
  logic          found_s;
  logic          take_s;

  // Rotating priority scan; found_s masks every candidate after the first hit.
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found_s  = 1'b0;
    take_s   = 1'b0;
    idx_s    = '0;
    for (int i = 1; i <= N; i++) begin
      idx_s          = IW'((int'(last_i) + i) % N);
      take_s         = req_i[idx_s] & ~found_s;
      found_s        = found_s | take_s;
      gnt_o[idx_s]   = gnt_o[idx_s] | take_s;
      gnt_id_o       = take_s ? idx_s : gnt_id_o;
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port between NUM_REQ valid/ready streams, granting
// round-robin bursts of up to MAX_BURST words with one idle cycle between grants.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int SIZE_DATA = DEF_SIZE_DATA,
  parameter  int MAX_BURST = 4,
  localparam int IW        = clog2_f(NUM_REQ),
  localparam int CW        = clog2_f(MAX_BURST + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*SIZE_DATA-1:0] i_req_data,
  output logic [NUM_REQ-1:0]           o_req_ready,
  input  logic                         i_fifo_full,
  output logic                         o_fifo_wr_en,
  output logic [SIZE_DATA-1:0]         o_fifo_data_wr,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic [IW-1:0]                o_grant_id,
  output logic                         o_busy
);

  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        grant_id_q, grant_id_d;
  logic [CW-1:0]        beat_q, beat_d;

  logic [NUM_REQ-1:0]   arb_gnt_s;
  logic [IW-1:0]        arb_id_s;
  logic                 any_req_s;
  logic                 granted_s;
  logic                 sel_valid_s;
  logic                 xfer_s;
  logic [SIZE_DATA-1:0] sel_data_s;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req_i     (i_req_valid),
    .last_i    (grant_id_q),
    .gnt_o     (arb_gnt_s),
    .gnt_id_o  (arb_id_s),
    .any_req_o (any_req_s)
  );

  // AND-OR data mux keyed by the registered grant; all zero while nobody holds it.
  always_comb begin
    sel_data_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_data_s = sel_data_s
                 | (i_req_data[k*SIZE_DATA +: SIZE_DATA] & {SIZE_DATA{grant_q[k]}});
    end
  end

  assign granted_s      = (state_q == ST_GRANT);
  assign sel_valid_s    = |(i_req_valid & grant_q);
  assign o_req_ready    = grant_q & {NUM_REQ{granted_s & ~i_fifo_full}};
  assign xfer_s         = |(i_req_valid & o_req_ready);
  assign o_fifo_wr_en   = xfer_s;
  assign o_fifo_data_wr = sel_data_s;
  assign o_grant        = grant_q;
  assign o_grant_id     = grant_id_q;
  assign o_busy         = granted_s;

  // Grant sequencing: every re-arbitration passes through IDLE.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    beat_d     = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (i_en && any_req_s) begin
          state_d    = ST_GRANT;
          grant_d    = arb_gnt_s;
          grant_id_d = arb_id_s;
          beat_d     = '0;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (xfer_s) begin
          if (beat_q == LAST_BEAT) begin
            state_d = ST_IDLE;
            grant_d = '0;
            beat_d  = '0;
          end else begin
            beat_d  = beat_q + CW'(1);
          end
        end else if (!sel_valid_s) begin
          state_d = ST_IDLE;
          grant_d = '0;
          beat_d  = '0;
        end else begin
          // full FIFO with data pending: hold the grant and the count
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        beat_d  = '0;
      end
    endcase
  end

  // State registers; the pointer resets to the last index so requester 0 wins first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      grant_id_q <= IW'(NUM_REQ - 1);
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      beat_q     <= beat_d;
    end
  end

endmodule
